// File: rtl/left_shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the sequential left shifter and its sibling
// right-shift unit.
//   shift_state_t  : controller states (IDLE, SHIFT, DONE)
//   ST_INVALID     : status bit index, operand had an invalid count encoding
//   ST_LOST        : status bit index, a 1 was shifted out of the MSB
//   ST_ZERO        : status bit index, result is all zeros
//   ST_ERR_INVALID : complete status word reported for an invalid operand
//   pack_status()  : assembles a status word from its individual flags
// ---------------------------------------------------------------------------
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_t;

   localparam int ST_W       = 4;
   localparam int ST_INVALID = 3;
   localparam int ST_LOST    = 2;
   localparam int ST_ZERO    = 1;

   localparam logic [ST_W-1:0] ST_ERR_INVALID = 4'b1000;

   // Bit 0 is reserved and is always left at zero.
   function automatic logic [ST_W-1:0] pack_status(input logic invalid,
                                                   input logic lost,
                                                   input logic zero);
      logic [ST_W-1:0] s;
      s             = '0;
      s[ST_INVALID] = invalid;
      s[ST_LOST]    = lost;
      s[ST_ZERO]    = zero;
      return s;
   endfunction

endpackage

// File: rtl/left_shift_seq_if.sv
// ---------------------------------------------------------------------------
// left_shift_seq_if
// Request/response bundle between the ALU operation mux and the sequential
// left shifter.
//   i_start  : request, only honoured while the shifter is idle
//   i_arg_A  : operand to shift (M bits)
//   i_arg_B  : shift count, inverted encoding (count = ~i_arg_B), valid only
//              when its MSB is 1
//   o_busy   : shifter is working or presenting a result
//   o_done   : one-cycle pulse, result and status valid
//   o_result : shifted value (M bits)
//   o_status : {invalid, lost, zero, 1'b0}
// master = requester side, slave = shifter side.
// ---------------------------------------------------------------------------
interface left_shift_seq_if #(parameter int M = 8);

   logic         i_start;
   logic [M-1:0] i_arg_A;
   logic [M-1:0] i_arg_B;
   logic         o_busy;
   logic         o_done;
   logic [M-1:0] o_result;
   logic [3:0]   o_status;

   modport master (
      output i_start, i_arg_A, i_arg_B,
      input  o_busy, o_done, o_result, o_status
   );

   modport slave (
      input  i_start, i_arg_A, i_arg_B,
      output o_busy, o_done, o_result, o_status
   );

endinterface

// File: rtl/left_shift_seq.sv
// ---------------------------------------------------------------------------
// left_shift_seq
// Sequential logical left shifter, one bit per clock, zero fill. The shift
// count arrives in the same inverted encoding used by the combinational
// right-shift unit and is saturated to M. Result and status are registered
// and held until the next accepted request completes.
//   i_clk : clock, all state changes on the rising edge
//   i_rst : synchronous active-high reset, aborts any operation in flight
//   bus   : left_shift_seq_if slave modport (start, operands, busy, done,
//           result, status)
// ---------------------------------------------------------------------------
module left_shift_seq
   import shift_pkg::*;
#(
   parameter int M = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   left_shift_seq_if.slave  bus
);

   // Counter must be able to hold the saturated value M itself.
   localparam int CW = $clog2(M + 1);

   shift_state_t      state;
   logic [M-1:0]      work;
   logic [CW-1:0]     cnt;
   logic              lost;
   logic              busy_q;
   logic              done_q;
   logic [M-1:0]      result_q;
   logic [ST_W-1:0]   status_q;

   logic [M-1:0]      n_raw;
   logic [CW-1:0]     n_sat;
   logic [M-1:0]      work_next;
   logic              lost_next;

   // Decode the inverted count and clamp anything at or above M to M, since
   // shifting further than the width only produces more zeros.
   always_comb begin
      n_raw = ~bus.i_arg_B;
      if (n_raw >= M'(M)) begin
         n_sat = CW'(M);
      end else begin
         n_sat = CW'(n_raw);
      end
   end

   // One step of the shift; the bit leaving the MSB folds into the lost flag.
   always_comb begin
      work_next = {work[M-2:0], 1'b0};
      lost_next = lost | work[M-1];
   end

   // Controller. The outputs are written on the edge that enters DONE so the
   // result, status and done pulse all appear together, and result/status
   // simply keep their value outside that edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         work     <= '0;
         cnt      <= '0;
         lost     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         status_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  work   <= bus.i_arg_A;
                  lost   <= 1'b0;
                  cnt    <= n_sat;
                  busy_q <= 1'b1;
                  if (!bus.i_arg_B[M-1]) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= '0;
                     status_q <= ST_ERR_INVALID;
                  end else if (n_sat == '0) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= bus.i_arg_A;
                     status_q <= pack_status(1'b0, 1'b0, bus.i_arg_A == '0);
                  end else begin
                     state <= SHIFT;
                  end
               end
            end

            SHIFT: begin
               work <= work_next;
               lost <= lost_next;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state    <= DONE;
                  done_q   <= 1'b1;
                  result_q <= work_next;
                  status_q <= pack_status(1'b0, lost_next, work_next == '0);
               end
            end

            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;
   assign bus.o_result = result_q;
   assign bus.o_status = status_q;

endmodule

// File: doc/left_shift_seq.md
# left_shift_seq

Sequential left shifter that complements the combinational right-shift unit in the ALU submodule set. It accepts an operand and a shift count in the same inverted encoding, and shifts left by one bit per clock under a start/busy/done handshake. It reports an invalid-operand, lost-bit and zero-result status alongside a registered result. It sits behind the ALU operation mux as a multi-cycle operation; the top level latches `o_result`/`o_status` on `o_done`.

## Interface
- `M`, 8: operand and result width in bits (M ≥ 2).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_arg_A`  in  M  operand to shift.
- `i_arg_B`  in  M  shift count, inverted encoding: count = ~i_arg_B; valid only when i_arg_B[M-1] = 1.
- `o_busy`  out  1  high in SHIFT and DONE.
- `o_done`  out  1  one-cycle pulse; result and status valid in the same cycle.
- `o_result`  out  M  shifted value, registered.
- `o_status`  out  4  [3] invalid operand, [2] a 1 was shifted out, [1] result zero, [0] reserved, always 0.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE.** When `i_start` = 1:
  - Capture A into the working register.
  - Compute n = ~i_arg_B, saturated to M. Counts ≥ M give n = M.
  - Clear the lost-bit flag.
- **Transitions from IDLE:**
  - i_arg_B[M-1] = 0: go to DONE with status 4'b1000 and result '0. No shift is performed.
  - n = 0: go to DONE with result = A.
  - Otherwise: go to SHIFT with the counter = n.
- **SHIFT.** Each cycle:
  - work ← {work[M-2:0], 1'b0}.
  - lost ← lost | work[M-1].
  - Decrement the counter. When it reaches 1, go to DONE.
- **DONE.**
  - `o_done` = 1 for exactly one cycle, then return to IDLE.
  - `o_result` = work.
  - `o_status` = {invalid, lost, (work == 0), 1'b0}. Zero is not flagged on an invalid operand: invalid status is exactly 4'b1000.
- `o_result` and `o_status` hold their values after DONE until the next accepted start. They update in the cycle the new DONE is reached.
- `i_start` while busy is ignored. Operands are not resampled and no request is queued.
- `i_start` held high across DONE→IDLE starts a new operation in the IDLE cycle, with a one-cycle gap between `o_done` pulses.
- Arithmetic: the shift is logical, zero fill; no sign handling. The lost flag is the OR of all bits shifted out of the MSB.

## Timing
- Reset values:
  - state IDLE.
  - `o_busy` 0, `o_done` 0.
  - `o_result` '0, `o_status` 4'b0000.
  - counter 0, lost 0.
- Reset mid-operation aborts within the same edge. The aborted operation produces no `o_done`.
- Latency, with start accepted at edge 0:
  - n ≥ 1 valid: `o_done` asserted in cycle n+1.
  - n = 0 or invalid operand: `o_done` asserted in cycle 1.
  - Worst case: M+1 cycles.
- `o_busy` rises the cycle after the start is accepted and falls together with `o_done`. Both are registered outputs with no combinational path from inputs.
- Throughput: one operation per (latency + 1) cycles.

## Structure
- Package `shift_pkg`:
  - `shift_state_t` enum (IDLE, SHIFT, DONE).
  - Status bit index constants: ST_INVALID = 3, ST_LOST = 2, ST_ZERO = 1.
  - `ST_ERR_INVALID` = 4'b1000, shared with the right-shift unit.
- Single module; no sub-module. The count decode and saturation is a few lines of combinational logic inside the block.

## Test plan (M = 8)
- A = 8'h81, B = 8'hFD (n = 2), start → `o_done` in cycle 3, result 8'h04, status 4'b0100.
- A = 8'h55, B = 8'h7F (MSB 0) → `o_done` in cycle 1, result 8'h00, status 4'b1000.
- A = 8'h3C, B = 8'hFF (n = 0) → `o_done` in cycle 1, result 8'h3C, status 4'b0000.
- A = 8'h01, B = 8'h80 (n = 127, saturates to 8) → `o_done` in cycle 9, result 8'h00, status 4'b0110; A = 8'h00 with the same B → status 4'b0010.
- Start A = 8'h01, B = 8'hF8 (n = 7); pulse `i_start` again in cycle 3 with different operands → ignored, `o_done` in cycle 8 with result 8'h80, status 4'b0000.
- Start with n = 5, assert `i_rst` in cycle 2 → next cycle IDLE with all outputs at reset values; no `o_done`; a following start with n = 1, A = 8'h40 gives result 8'h80 in cycle 2.
